// File: rtl/mem_ext_nx_if.sv
// Bus bundle between the PDP-8/e AC/IOT datapath (master) and the
// memory-extension / interrupt-control unit mem_ext_nx (slave).
interface mem_ext_nx_if #(
  parameter int FIELD_W = 3
);
  // datapath -> unit
  logic [0:11]        instruction;
  logic [0:11]        sr;
  logic [0:11]        ac;
  logic [4:0]         state;
  logic               clear;
  logic               extd_addrd;
  logic               gtf;
  logic               int_in_prog;
  logic               irq;
  // unit -> datapath
  logic               int_ena;
  logic               int_inh;
  logic               mskip;
  logic               UF;
  logic               UI;
  logic [0:FIELD_W-1] DF;
  logic [0:FIELD_W-1] IF;
  logic [0:11]        me_bus;
  logic [3:0]         stack_depth;
  logic               stack_ovf;

  modport master (
    output instruction, sr, ac, state, clear, extd_addrd, gtf, int_in_prog, irq,
    input  int_ena, int_inh, mskip, UF, UI, DF, IF, me_bus, stack_depth, stack_ovf
  );

  modport slave (
    input  instruction, sr, ac, state, clear, extd_addrd, gtf, int_in_prog, irq,
    output int_ena, int_inh, mskip, UF, UI, DF, IF, me_bus, stack_depth, stack_ovf
  );
endinterface

// File: rtl/mem_ext_nx.sv
// mem_ext_nx: PDP-8/e memory extension and interrupt control with wide
// fields (FIELD_W = 3..5, up to 128K words) and a nested interrupt save stack.
// Optional time-share (user mode) logic is enabled by defining TIME_SHARE_EN;
// without it UF/UB/UI stay 0 and no user traps are raised.
// Fields are held little-endian internally: bits [2:0] are the L part and the
// bits above are the X extension.
module mem_ext_nx #(
  parameter int FIELD_W    = 3,
  parameter int SAVE_DEPTH = 1
) (
  input  logic        clk,
  input  logic        reset,
  mem_ext_nx_if.slave bus
);

`ifdef TIME_SHARE_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  localparam int E  = FIELD_W - 3;
  localparam int SW = 1 + 2 * FIELD_W;   // stack entry {U, IF, DF}

  // Shared major-state encodings used by the datapath.
  localparam logic [4:0] F1 = 5'd1;
  localparam logic [4:0] F2 = 5'd2;
  localparam logic [4:0] F3 = 5'd3;
  localparam logic [4:0] D2 = 5'd6;
  localparam logic [4:0] E0 = 5'd8;
  localparam logic [4:0] E2 = 5'd10;
  localparam logic [4:0] H1 = 5'd13;

  // Replace the L part of a field.
  function automatic logic [FIELD_W-1:0] set_l(input logic [FIELD_W-1:0] f,
                                               input logic [2:0] l);
    logic [7:0] t;
    t      = 8'(f);
    t[2:0] = l;
    return FIELD_W'(t);
  endfunction

  // Replace the X part of a field; bits above E are dropped by the narrowing.
  function automatic logic [FIELD_W-1:0] set_x(input logic [FIELD_W-1:0] f,
                                               input logic [1:0] x);
    logic [7:0] t;
    t      = 8'(f);
    t[7:3] = 5'(x);
    return FIELD_W'(t);
  endfunction

  // X part of a field, zero when the field has no extension.
  function automatic logic [1:0] get_x(input logic [FIELD_W-1:0] f);
    logic [7:0] t;
    t = 8'(f) >> 3;
    return t[1:0];
  endfunction

  logic [FIELD_W-1:0] if_reg, if_next, ib_reg, ib_next, df_reg, df_next;
  logic               uf_reg, uf_next, ub_reg, ub_next, ui_reg, ui_next;
  logic               int_ena_reg, int_ena_next, int_delay_reg, int_delay_next;
  logic               int_inh_reg, int_inh_next, mskip_reg, mskip_next;
  logic [11:0]        me_bus_reg, me_bus_next;
  logic [3:0]         depth_reg, depth_next;
  logic               ovf_reg, ovf_next;

  logic [11:0] ir, acv, srv, rxb;
  logic        is_iot, is_jmp, is_jms, hlt_osr, cdf_cif, user, skip, tx;
  logic        push, full;
  logic [SW-1:0] push_data, top;
  logic [6:0]    top_lview;
  logic [SW-1:0] stack_view [SAVE_DEPTH];

  assign ir  = bus.instruction;
  assign acv = bus.ac;
  assign srv = bus.sr;

  wire unused_sr = &{1'b0, srv[11:6]};

  assign is_iot  = (ir[11:9] == 3'o6);
  assign is_jmp  = (ir[11:9] == 3'o5);
  assign is_jms  = (ir[11:9] == 3'o4);
  // Group-2 operate with HLT or OSR (covers LAS).
  assign hlt_osr = (ir[11:8] == 4'hF) && !ir[0] && (ir[1] || ir[2]);
  // 62N1 / 62N2 / 62N3
  assign cdf_cif = (ir[11:6] == 6'o62) && !ir[2] && (ir[1] || ir[0]);
  assign user    = TS_EN && uf_reg;

  assign skip = (ir == 12'o6000 && !uf_reg && int_ena_reg) ||
                (ir == 12'o6003 && !uf_reg && bus.irq) ||
                (ir == 12'o6006 && bus.gtf) ||
                (TS_EN && ir == 12'o6254 && !uf_reg && ui_reg);

  // IB/UB -> IF/UF happens on the first jump-type transfer after CIF/RTF/RMF.
  assign tx = int_inh_reg &&
              ((bus.state == F2 && is_jmp && !ir[8]) ||
               (bus.state == D2 && is_jmp) ||
               (bus.state == E2 && is_jms));

  assign rxb       = (12'(get_x(if_reg)) << E) | 12'(get_x(df_reg));
  assign full      = (depth_reg == 4'(SAVE_DEPTH));
  assign push_data = {uf_reg & TS_EN, if_reg, df_reg};
  assign top_lview = {top[SW-1], top[FIELD_W+2:FIELD_W], top[2:0]};

  // Save stack slots: a slot takes the new context when it is the next free
  // one, or shifts down from the slot above when the stack is already full.
  for (genvar gi = 0; gi < SAVE_DEPTH; gi++) begin : g_stk
    logic [SW-1:0] entry_reg;
    logic [SW-1:0] shift_in;
    if (gi == SAVE_DEPTH - 1) begin : g_top
      assign shift_in = push_data;
    end else begin : g_mid
      assign shift_in = stack_view[gi+1];
    end

    // Slot register, cleared with the rest of the unit.
    always_ff @(posedge clk) begin
      if (!reset || bus.clear) begin
        entry_reg <= '0;
      end else if (push) begin
        if (full) begin
          entry_reg <= shift_in;
        end else if (depth_reg == 4'(gi)) begin
          entry_reg <= push_data;
        end
      end
    end

    assign stack_view[gi] = entry_reg;
  end

  // Top of stack: entry depth-1, or entry 0 when empty.
  always_comb begin
    top = stack_view[0];
    for (int i = 0; i < SAVE_DEPTH; i++) begin
      if (depth_reg != 4'd0 && 4'(i) == depth_reg - 4'd1) begin
        top = stack_view[i];
      end
    end
  end

  // Next-state logic, stepped by the major state code.
  always_comb begin
    if_next        = if_reg;
    ib_next        = ib_reg;
    df_next        = df_reg;
    uf_next        = uf_reg;
    ub_next        = ub_reg;
    ui_next        = ui_reg;
    int_ena_next   = int_ena_reg;
    int_delay_next = int_delay_reg;
    int_inh_next   = int_inh_reg;
    mskip_next     = mskip_reg;
    me_bus_next    = me_bus_reg;
    depth_next     = depth_reg;
    ovf_next       = ovf_reg;
    push           = 1'b0;

    case (bus.state)
      F1: begin
        if (skip) mskip_next = 1'b1;
      end
      F2: begin
        // One-instruction ION delay expires here.
        if (int_delay_reg) begin
          int_ena_next   = 1'b1;
          int_delay_next = 1'b0;
        end
        if (user) begin
          if (is_iot || hlt_osr) ui_next = 1'b1;
        end else begin
          case (ir)
            12'o6004: me_bus_next = {2'b00, bus.irq, 1'b0,
                                     int_ena_reg | int_delay_reg, top_lview};
            12'o6214: me_bus_next = acv | (12'(df_reg[2:0]) << 3);
            12'o6224: me_bus_next = acv | (12'(if_reg[2:0]) << 3);
            12'o6234: me_bus_next = acv | 12'(top_lview);
            12'o6215: me_bus_next = acv | rxb;
            12'o6204: ui_next     = 1'b0;
            default:  ;
          endcase
        end
      end
      F3: begin
        mskip_next = 1'b0;
        if (!user && is_iot) begin
          case (ir)
            12'o6000, 12'o6002: begin
              int_ena_next   = 1'b0;
              int_delay_next = 1'b0;
            end
            12'o6001: int_delay_next = 1'b1;
            12'o6005: begin
              ub_next        = acv[6] & TS_EN;
              ib_next        = set_l(ib_reg, acv[5:3]);
              df_next        = set_l(df_reg, acv[2:0]);
              int_delay_next = 1'b1;
              int_inh_next   = 1'b1;
            end
            12'o6007: begin
              int_ena_next   = 1'b0;
              int_delay_next = 1'b0;
              uf_next        = 1'b0;
              ui_next        = 1'b0;
              depth_next     = 4'd0;
              ovf_next       = 1'b0;
            end
            12'o6205: begin
              if (E > 0) begin
                df_next      = set_x(df_reg, acv[3:2]);
                ib_next      = set_x(ib_reg, acv[1:0]);
                int_inh_next = 1'b1;
              end
            end
            12'o6264: begin
              if (TS_EN) ub_next = 1'b0;
            end
            12'o6274: begin
              if (TS_EN) begin
                ub_next      = 1'b1;
                int_inh_next = 1'b1;
              end
            end
            12'o6244: begin
              ub_next      = top[SW-1] & TS_EN;
              ib_next      = top[SW-2:FIELD_W];
              df_next      = top[FIELD_W-1:0];
              int_inh_next = 1'b1;
              if (depth_reg != 4'd0) depth_next = depth_reg - 4'd1;
            end
            default: ;
          endcase
          if (cdf_cif) begin
            if (ir[0]) df_next = set_l(df_reg, ir[5:3]);
            if (ir[1]) begin
              ib_next      = set_l(ib_reg, ir[5:3]);
              int_inh_next = 1'b1;
            end
          end
        end
      end
      E0: begin
        if (bus.int_in_prog) begin
          push = 1'b1;
          if (full) ovf_next = 1'b1;
          else      depth_next = depth_reg + 4'd1;
          if_next        = '0;
          df_next        = '0;
          uf_next        = 1'b0;
          ub_next        = 1'b0;
          int_ena_next   = 1'b0;
          int_delay_next = 1'b0;
        end
      end
      H1: begin
        if (bus.extd_addrd) begin
          if_next = FIELD_W'(srv[5:3]);
          ib_next = FIELD_W'(srv[5:3]);
          df_next = FIELD_W'(srv[2:0]);
          uf_next = 1'b0;
          ub_next = 1'b0;
        end
      end
      default: ;
    endcase

    if (tx) begin
      if_next      = ib_reg;
      uf_next      = ub_reg & TS_EN;
      int_inh_next = 1'b0;
    end
  end

  // State registers; a panel clear is a full clear (it also covers H2).
  always_ff @(posedge clk) begin
    if (!reset || bus.clear) begin
      if_reg        <= '0;
      ib_reg        <= '0;
      df_reg        <= '0;
      uf_reg        <= 1'b0;
      ub_reg        <= 1'b0;
      ui_reg        <= 1'b0;
      int_ena_reg   <= 1'b0;
      int_delay_reg <= 1'b0;
      int_inh_reg   <= 1'b0;
      mskip_reg     <= 1'b0;
      me_bus_reg    <= '0;
      depth_reg     <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      if_reg        <= if_next;
      ib_reg        <= ib_next;
      df_reg        <= df_next;
      uf_reg        <= uf_next;
      ub_reg        <= ub_next;
      ui_reg        <= ui_next;
      int_ena_reg   <= int_ena_next;
      int_delay_reg <= int_delay_next;
      int_inh_reg   <= int_inh_next;
      mskip_reg     <= mskip_next;
      me_bus_reg    <= me_bus_next;
      depth_reg     <= depth_next;
      ovf_reg       <= ovf_next;
    end
  end

  assign bus.int_ena     = int_ena_reg;
  assign bus.int_inh     = int_inh_reg;
  assign bus.mskip       = mskip_reg;
  assign bus.UF          = uf_reg;
  assign bus.UI          = ui_reg;
  assign bus.DF          = df_reg;
  assign bus.IF          = if_reg;
  assign bus.me_bus      = me_bus_reg;
  assign bus.stack_depth = depth_reg;
  assign bus.stack_ovf   = ovf_reg;

endmodule
